i2c_target_regfile: RTL and testbench
=====================================

# i2c_target_regfile

I2C target (slave) with a local byte-register file. It is the far-end counterpart of the fabric I2C controller: it sits on the same SCL/SDA pair and answers that controller's address, write and read transfers. Registers are readable and writable over I2C, visible to fabric logic in parallel, and loadable from fabric logic. Open-drain pads are external; this block sees split in/out signals, with 1 meaning released.

## Interface
- TARGET_ADDR, 7'h50, 7-bit I2C address this target answers.
- NUM_REGS, 16, register count; power of two, 2..256.
- FILTER_LEN, 3, glitch-filter depth in PCLK samples, 1..8.
- PCLK  in  1  system clock; must be at least 20x the SCL rate.
- PRESETN  in  1  asynchronous active-low reset.
- SCLI  in  1  SCL pad input.
- SDAI  in  1  SDA pad input.
- SCLO  out  1  SCL drive; always 1 (no clock stretching).
- SDAO  out  1  SDA drive; 0 pulls the line low.
- FAB_WE  in  1  fabric register write strobe.
- FAB_ADDR  in  log2(NUM_REGS)  fabric write index.
- FAB_WDATA  in  8  fabric write data.
- REGS_FLAT  out  8*NUM_REGS  all registers; register k is on bits [8k+7:8k].
- BUSY  out  1  high between a detected START and the next STOP.
- INT  out  1  one-cycle pulse at STOP if any register was written over I2C during the transfer.

## Operation
**Input conditioning**
- Each of SCLI and SDAI passes through a 2-flop synchronizer, then a filter.
- The filtered value changes only when the last FILTER_LEN synchronized samples agree.
- All edge and condition detection below uses the filtered signals.

**Bus conditions**
- START: SDA falls while SCL is high.
- STOP: SDA rises while SCL is high.
- START or repeated START, from any state: go to ADDR and clear the bit counter.
- STOP, from any state: go to IDLE, set SDAO=1, and pulse INT if the written flag is set.

**Bit timing**
- Bits are sampled on the SCL rising edge, MSB first.
- SDAO changes only on the SCL falling edge.

**States**
- IDLE: SDAO=1; waits for START.
- ADDR: shift in 8 bits. On the 8th SCL falling edge:
  - if bits[7:1]==TARGET_ADDR, drive ACK (SDAO=0) and go to ADDR_ACK with R/W = bit[0];
  - otherwise go to IGNORE.
- IGNORE: SDAO=1 until START or STOP.
- ADDR_ACK: on the next SCL falling edge, release SDA. Then:
  - W: go to PTR;
  - R: load shift register from reg[ptr], drive its MSB and go to RD_DATA.
- PTR: shift in 8 bits. The pointer takes the low log2(NUM_REGS) bits; upper bits are ignored. ACK, then go to WR_DATA.
- WR_DATA: shift in 8 bits. At the 8th rising edge:
  - write reg[ptr];
  - set the written flag;
  - ptr = ptr+1, modulo NUM_REGS.
  - Then ACK on the falling edge. Every data byte is ACKed.
- RD_DATA: drive 8 bits, then release SDA and go to RD_ACK. The pointer increments, with wrap, after each byte is transmitted.
- RD_ACK: sample SDA on the SCL rising edge.
  - 0 (ACK): on the falling edge, load reg[ptr] and continue in RD_DATA.
  - 1 (NACK): go to IGNORE and wait for STOP or repeated START.

**Register state**
- The pointer persists across transfers and is reset to 0 by PRESETN only.
- A write-then-repeated-START-read sequence reads from the pointer just written.
- The written flag clears at START.

**Collisions and reset**
- If FAB_WE and an I2C write hit the same register in the same cycle, the fabric write wins and the I2C byte is dropped. It is still ACKed and still increments the pointer.
- Writes to different registers in the same cycle both complete.
- PRESETN assertion mid-transfer: all state returns to reset values immediately and SDA is released. The block then waits for a fresh START; the rest of the in-flight bus transfer is ignored.

## Timing
**Reset values**
- SDAO=1, SCLO=1, BUSY=0, INT=0.
- REGS_FLAT=0, ptr=0, state IDLE.

**Latency from pad change to filtered edge**
- 2 + FILTER_LEN PCLK cycles.
- SDAO updates 1 cycle after the filtered SCL falling edge.
- A register update is visible on REGS_FLAT 1 cycle after the filtered 8th rising edge.

**Other output timing**
- INT is high for exactly 1 cycle, 1 cycle after STOP is detected.
- BUSY rises 1 cycle after START and falls 1 cycle after STOP.
- FAB_WE writes take effect on REGS_FLAT the next cycle.

**Bus behaviour**
- Input pulses shorter than FILTER_LEN PCLK cycles are rejected.
- SDAO never changes while the filtered SCL is high, except on release at STOP or reset.

## Test plan
- Write: START, 0xA0, ptr 0x03, data 0x5A, 0xC3, STOP -> all three bytes ACKed; reg3=0x5A, reg4=0xC3; INT pulses once; ptr=5.
- Wrapping read: FAB_WE sets reg15=0x11 and reg0=0x22; then START, 0xA0, ptr 0x0F, repeated START, 0xA1, read 2 bytes (ACK then NACK), STOP -> bytes read are 0x11 then 0x22; ptr=1; INT not pulsed.
- Wrong address: START, 0xA2, 0x00, 0xFF, STOP -> no ACK on any bit; SDAO stays 1 throughout; registers unchanged; no INT.
- Glitches: a 1-PCLK low pulse on SCL mid-byte with FILTER_LEN=3 -> ignored and the byte is received correctly; a 1-PCLK SDA dip while SCL is high -> no false START.
- Collision: FAB_WE writes 0x77 to reg2 in the same cycle as an I2C write of 0x99 to reg2 -> reg2=0x77; the I2C byte is still ACKed; ptr=3.
- Reset mid-transfer: PRESETN pulsed low during ACK low time -> SDAO=1 immediately and all registers 0; the next complete write transfer succeeds.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte register file that fabric logic can observe and load in parallel.
// SCL/SDA are synchronized and glitch-filtered; all bus decoding runs on the filtered pair.
module i2c_target_regfile #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int          NUM_REGS    = 16,
    parameter int          FILTER_LEN  = 3
) (
    input  logic                        PCLK,
    input  logic                        PRESETN,
    input  logic                        SCLI,
    input  logic                        SDAI,
    output logic                        SCLO,
    output logic                        SDAO,
    input  logic                        FAB_WE,
    input  logic [$clog2(NUM_REGS)-1:0] FAB_ADDR,
    input  logic [7:0]                  FAB_WDATA,
    output logic [8*NUM_REGS-1:0]       REGS_FLAT,
    output logic                        BUSY,
    output logic                        INT
);
    localparam int PTR_W = $clog2(NUM_REGS);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_ADDR     = 4'd1;
    localparam logic [3:0] S_IGNORE   = 4'd2;
    localparam logic [3:0] S_ADDR_ACK = 4'd3;
    localparam logic [3:0] S_PTR      = 4'd4;
    localparam logic [3:0] S_PTR_ACK  = 4'd5;
    localparam logic [3:0] S_WR_DATA  = 4'd6;
    localparam logic [3:0] S_WR_ACK   = 4'd7;
    localparam logic [3:0] S_RD_DATA  = 4'd8;
    localparam logic [3:0] S_RD_ACK   = 4'd9;

    function automatic logic [FILTER_LEN-1:0] hist_shift(input logic [FILTER_LEN-1:0] h,
                                                         input logic b);
        logic [FILTER_LEN:0] t;
        t = {h, b};
        return t[FILTER_LEN-1:0];
    endfunction

    // bit 0 carries SCL, bit 1 carries SDA through every conditioning stage
    logic [1:0]            meta_q, sync_q, filt_q, filt_prev_q, filt_d;
    logic [FILTER_LEN-1:0] hist_scl_q, hist_sda_q, hist_scl_d, hist_sda_d;

    always_comb begin
        hist_scl_d = hist_shift(hist_scl_q, sync_q[0]);
        hist_sda_d = hist_shift(hist_sda_q, sync_q[1]);
        filt_d     = filt_q;
        if (&hist_scl_d)       filt_d[0] = 1'b1;
        else if (~|hist_scl_d) filt_d[0] = 1'b0;
        if (&hist_sda_d)       filt_d[1] = 1'b1;
        else if (~|hist_sda_d) filt_d[1] = 1'b0;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            meta_q      <= 2'b11;
            sync_q      <= 2'b11;
            hist_scl_q  <= '1;
            hist_sda_q  <= '1;
            filt_q      <= 2'b11;
            filt_prev_q <= 2'b11;
        end else begin
            meta_q      <= {SDAI, SCLI};
            sync_q      <= meta_q;
            hist_scl_q  <= hist_scl_d;
            hist_sda_q  <= hist_sda_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
        end
    end

    logic scl_rise, scl_fall, scl_hi, start_det, stop_det, sda_in;

    assign sda_in    = filt_q[1];
    assign scl_hi    = filt_q[0] & filt_prev_q[0];
    assign scl_rise  = filt_q[0] & ~filt_prev_q[0];
    assign scl_fall  = ~filt_q[0] & filt_prev_q[0];
    assign start_det = scl_hi & filt_prev_q[1] & ~filt_q[1];
    assign stop_det  = scl_hi & ~filt_prev_q[1] & filt_q[1];

    logic [3:0]            state_q, state_d, bitcnt_q, bitcnt_d;
    logic [7:0]            shift_q, shift_d, rd_byte, i2c_wdata;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  rw_q, rw_d, ack_q, ack_d, written_q, written_d;
    logic                  sdao_q, sdao_d, busy_q, busy_d, int_q, int_d, i2c_we;
    logic [8*NUM_REGS-1:0] regs_q, regs_d;

    assign rd_byte   = regs_q[{ptr_q, 3'b000} +: 8];
    assign i2c_wdata = {shift_q[6:0], sda_in};

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        ack_d     = ack_q;
        written_d = written_q;
        sdao_d    = sdao_q;
        busy_d    = busy_q;
        int_d     = 1'b0;
        i2c_we    = 1'b0;
        if (stop_det) begin
            state_d = S_IDLE;
            sdao_d  = 1'b1;
            busy_d  = 1'b0;
            int_d   = written_q;
        end else if (start_det) begin
            state_d   = S_ADDR;
            bitcnt_d  = 4'd0;
            written_d = 1'b0;
            busy_d    = 1'b1;
            sdao_d    = 1'b1;
        end else begin
            case (state_q)
                S_ADDR, S_PTR: begin
                    if (scl_rise) begin
                        shift_d  = {shift_q[6:0], sda_in};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        if (state_q == S_PTR) begin
                            ptr_d   = shift_q[PTR_W-1:0];
                            sdao_d  = 1'b0;
                            state_d = S_PTR_ACK;
                        end else if (shift_q[7:1] == TARGET_ADDR) begin
                            rw_d    = shift_q[0];
                            sdao_d  = 1'b0;
                            state_d = S_ADDR_ACK;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        bitcnt_d = 4'd0;
                        if (rw_q) begin
                            shift_d = rd_byte;
                            sdao_d  = rd_byte[7];
                            state_d = S_RD_DATA;
                        end else begin
                            sdao_d  = 1'b1;
                            state_d = S_PTR;
                        end
                    end
                end
                S_PTR_ACK, S_WR_ACK: begin
                    if (scl_fall) begin
                        sdao_d   = 1'b1;
                        bitcnt_d = 4'd0;
                        state_d  = S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d  = i2c_wdata;
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            i2c_we    = 1'b1;
                            written_d = 1'b1;
                            ptr_d     = ptr_q + 1'b1;
                        end
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        sdao_d  = 1'b0;
                        state_d = S_WR_ACK;
                    end
                end
                S_RD_DATA: begin
                    // MSB went out on entry; each fall shifts the next bit onto the line
                    if (scl_fall) begin
                        if (bitcnt_q == 4'd7) begin
                            sdao_d   = 1'b1;
                            ptr_d    = ptr_q + 1'b1;
                            bitcnt_d = 4'd0;
                            state_d  = S_RD_ACK;
                        end else begin
                            sdao_d   = shift_q[6];
                            shift_d  = {shift_q[6:0], 1'b0};
                            bitcnt_d = bitcnt_q + 4'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        ack_d = sda_in;
                    end else if (scl_fall) begin
                        if (!ack_q) begin
                            shift_d  = rd_byte;
                            sdao_d   = rd_byte[7];
                            bitcnt_d = 4'd0;
                            state_d  = S_RD_DATA;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // fabric write is applied last so it wins a same-register collision
    always_comb begin
        regs_d = regs_q;
        if (i2c_we) regs_d[{ptr_q, 3'b000} +: 8] = i2c_wdata;
        if (FAB_WE) regs_d[{FAB_ADDR, 3'b000} +: 8] = FAB_WDATA;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q   <= S_IDLE;
            bitcnt_q  <= 4'd0;
            shift_q   <= 8'h00;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            ack_q     <= 1'b1;
            written_q <= 1'b0;
            sdao_q    <= 1'b1;
            busy_q    <= 1'b0;
            int_q     <= 1'b0;
            regs_q    <= '0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            ack_q     <= ack_d;
            written_q <= written_d;
            sdao_q    <= sdao_d;
            busy_q    <= busy_d;
            int_q     <= int_d;
            regs_q    <= regs_d;
        end
    end

    assign SCLO      = 1'b1;
    assign SDAO      = sdao_q;
    assign BUSY      = busy_q;
    assign INT       = int_q;
    assign REGS_FLAT = regs_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: a bit-banged I2C controller, a register model and a
// queue of expected ACK bits / read bytes compared as the target answers.
module tb_i2c_target_regfile;
    localparam int Q = 10;

    logic         pclk = 1'b0;
    logic         presetn = 1'b0;
    logic         scl_m = 1'b1;
    logic         sda_m = 1'b1;
    logic         sdai_w;
    logic         scl_o, sdao, busy, intr;
    logic         fab_we = 1'b0;
    logic [3:0]   fab_addr = 4'd0;
    logic [7:0]   fab_wdata = 8'd0;
    logic [127:0] regs_flat;

    assign sdai_w = sda_m & sdao;

    i2c_target_regfile #(.TARGET_ADDR(7'h50), .NUM_REGS(16), .FILTER_LEN(3)) dut (
        .PCLK(pclk), .PRESETN(presetn), .SCLI(scl_m), .SDAI(sdai_w),
        .SCLO(scl_o), .SDAO(sdao), .FAB_WE(fab_we), .FAB_ADDR(fab_addr),
        .FAB_WDATA(fab_wdata), .REGS_FLAT(regs_flat), .BUSY(busy), .INT(intr)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int failures = 0;
    int int_cnt = 0, int_wide = 0, viol = 0, sdao_low_cnt = 0, busy_cnt = 0;
    logic int_prev = 1'b0, sdao_prev = 1'b1;

    always @(negedge pclk) begin
        if (intr) int_cnt++;
        if (intr && int_prev) int_wide++;
        int_prev = intr;
        if (presetn && (sdao !== sdao_prev) && scl_m) viol++;
        sdao_prev = sdao;
        if (!sdao) sdao_low_cnt++;
        if (busy) busy_cnt++;
    end

    logic [7:0] mregs [16];
    int         mptr;
    logic [7:0] exp_q [$];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] ptr;
        logic [7:0] d0;
        logic [7:0] d1;
        int         n;
        logic       ack_lvl;
        int         exp_int;
    } wvec_t;
    wvec_t vec [4];

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        for (int k = 0; k < 16; k++) f[k*8 +: 8] = mregs[k];
        return f;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic sb_check(input string nm, input logic [7:0] act);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s actual=%0h required=<queue empty>", nm, act);
        end else begin
            chk(nm, {120'd0, act}, {120'd0, exp_q.pop_front()});
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    // mode 1: one-PCLK SCL glitch while high; mode 2: fabric write on the DUT's sampling cycle
    task automatic write_bit(input logic b, input int mode, input logic [3:0] fa, input logic [7:0] fd);
        sda_m = b;
        wait_cyc(Q);
        scl_m = 1'b1;
        if (mode == 2) begin
            wait_cyc(5);
            fab_we = 1'b1; fab_addr = fa; fab_wdata = fd;
            wait_cyc(1);
            fab_we = 1'b0;
            wait_cyc(2*Q - 6);
        end else if (mode == 1) begin
            wait_cyc(8);
            scl_m = 1'b0;
            wait_cyc(1);
            scl_m = 1'b1;
            wait_cyc(2*Q - 9);
        end else begin
            wait_cyc(2*Q);
        end
        scl_m = 1'b0;
        wait_cyc(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1;
        wait_cyc(Q);
        scl_m = 1'b1;
        wait_cyc(Q);
        b = sdai_w;
        wait_cyc(Q);
        scl_m = 1'b0;
        wait_cyc(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input int gbit, input int fbit,
                              input logic [3:0] fa, input logic [7:0] fd);
        logic a;
        for (int i = 7; i >= 0; i--)
            write_bit(d[i], (i == gbit) ? 1 : ((i == fbit) ? 2 : 0), fa, fd);
        read_bit(a);
        sb_check("ack", {7'd0, a});
    endtask

    task automatic wb(input logic [7:0] d, input logic ack_lvl);
        exp_q.push_back({7'd0, ack_lvl});
        write_byte(d, -1, -1, 4'd0, 8'd0);
    endtask

    task automatic read_byte(input logic nack);
        logic [7:0] d;
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack, 0, 4'd0, 8'd0);
        sb_check("rd_byte", d);
    endtask

    task automatic i2c_start();
        sda_m = 1'b0; wait_cyc(Q);
        scl_m = 1'b0; wait_cyc(Q);
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; wait_cyc(Q);
        scl_m = 1'b1; wait_cyc(Q);
        sda_m = 1'b0; wait_cyc(Q);
        scl_m = 1'b0; wait_cyc(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_cyc(Q);
        scl_m = 1'b1; wait_cyc(Q);
        sda_m = 1'b1; wait_cyc(2*Q);
    endtask

    task automatic fab_write(input logic [3:0] a, input logic [7:0] d);
        fab_we = 1'b1; fab_addr = a; fab_wdata = d;
        wait_cyc(1);
        fab_we = 1'b0;
        mregs[a] = d;
    endtask

    // current-address read of one byte: proves where the pointer sits
    task automatic readback();
        i2c_start();
        wb(8'hA1, 1'b0);
        exp_q.push_back(mregs[mptr]);
        read_byte(1'b1);
        mptr = (mptr + 1) % 16;
        i2c_stop();
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ib, sb, bb;
        for (int k = 0; k < 16; k++) mregs[k] = 8'h00;
        mptr = 0;
        vec[0] = '{addr: 8'hA0, ptr: 8'h03, d0: 8'h5A, d1: 8'hC3, n: 2, ack_lvl: 1'b0, exp_int: 1};
        vec[1] = '{addr: 8'hA2, ptr: 8'h00, d0: 8'hFF, d1: 8'h00, n: 1, ack_lvl: 1'b1, exp_int: 0};
        vec[2] = '{addr: 8'hA0, ptr: 8'h1E, d0: 8'hAB, d1: 8'hCD, n: 2, ack_lvl: 1'b0, exp_int: 1};
        vec[3] = '{addr: 8'hA0, ptr: 8'h07, d0: 8'h01, d1: 8'h00, n: 1, ack_lvl: 1'b0, exp_int: 1};

        wait_cyc(3);
        chk("rst_sdao", {127'd0, sdao}, 128'd1);
        chk("rst_sclo", {127'd0, scl_o}, 128'd1);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_int", {127'd0, intr}, 128'd0);
        chk("rst_regs", regs_flat, 128'd0);
        presetn = 1'b1;
        wait_cyc(10);

        fab_write(4'd0, 8'hC0);
        chk("fab_next_cycle", {120'd0, regs_flat[7:0]}, 128'hC0);
        for (int k = 1; k < 16; k++) fab_write(k[3:0], 8'hC0 + k[7:0]);
        wait_cyc(1);
        chk("fab_prefill", regs_flat, model_flat());

        for (int v = 0; v < 4; v++) begin
            ib = int_cnt;
            sb = sdao_low_cnt;
            i2c_start();
            chk("busy_in_xfer", {127'd0, busy}, 128'd1);
            wb(vec[v].addr, vec[v].ack_lvl);
            wb(vec[v].ptr, vec[v].ack_lvl);
            wb(vec[v].d0, vec[v].ack_lvl);
            if (vec[v].n > 1) wb(vec[v].d1, vec[v].ack_lvl);
            i2c_stop();
            if (vec[v].addr[7:1] == 7'h50) begin
                mptr = vec[v].ptr[3:0];
                mregs[mptr] = vec[v].d0;
                mptr = (mptr + 1) % 16;
                if (vec[v].n > 1) begin
                    mregs[mptr] = vec[v].d1;
                    mptr = (mptr + 1) % 16;
                end
            end else begin
                chk("sdao_stays_high", 128'(sdao_low_cnt - sb), 128'd0);
            end
            chk("int_count", 128'(int_cnt - ib), 128'(vec[v].exp_int));
            chk("busy_after_stop", {127'd0, busy}, 128'd0);
            chk("regs_after_write", regs_flat, model_flat());
            if (vec[v].addr[7:1] == 7'h50) readback();
        end

        // wrapping read with repeated START
        fab_write(4'd15, 8'h11);
        fab_write(4'd0, 8'h22);
        ib = int_cnt;
        i2c_start();
        wb(8'hA0, 1'b0);
        wb(8'h0F, 1'b0);
        i2c_rstart();
        wb(8'hA1, 1'b0);
        exp_q.push_back(8'h11);
        read_byte(1'b0);
        exp_q.push_back(8'h22);
        read_byte(1'b1);
        i2c_stop();
        mptr = 1;
        chk("wrap_read_no_int", 128'(int_cnt - ib), 128'd0);
        readback();

        // SDA dip while SCL high at idle must not start a transfer
        bb = busy_cnt;
        sda_m = 1'b0; wait_cyc(1); sda_m = 1'b1;
        wait_cyc(20);
        chk("no_false_start", 128'(busy_cnt - bb), 128'd0);

        // one-PCLK SCL glitch inside a data byte
        i2c_start();
        wb(8'hA0, 1'b0);
        wb(8'h06, 1'b0);
        exp_q.push_back(8'h00);
        write_byte(8'h96, 3, -1, 4'd0, 8'd0);
        i2c_stop();
        mregs[6] = 8'h96;
        mptr = 7;
        chk("glitch_byte", regs_flat, model_flat());
        readback();

        // same-register collision (fabric wins) and different-register concurrency
        ib = int_cnt;
        i2c_start();
        wb(8'hA0, 1'b0);
        wb(8'h02, 1'b0);
        exp_q.push_back(8'h00);
        write_byte(8'h99, -1, 0, 4'd2, 8'h77);
        exp_q.push_back(8'h00);
        write_byte(8'h44, -1, 0, 4'd9, 8'h12);
        i2c_stop();
        mregs[2] = 8'h77;
        mregs[3] = 8'h44;
        mregs[9] = 8'h12;
        mptr = 4;
        chk("collision_regs", regs_flat, model_flat());
        chk("collision_int", 128'(int_cnt - ib), 128'd1);
        readback();

        // reset while the target is holding ACK low
        i2c_start();
        wb(8'hA0, 1'b0);
        wb(8'h05, 1'b0);
        for (int i = 7; i >= 0; i--) write_bit(i[0], 0, 4'd0, 8'd0);
        chk("ack_before_reset", {127'd0, sdao}, 128'd0);
        presetn = 1'b0;
        #1;
        chk("reset_sdao", {127'd0, sdao}, 128'd1);
        chk("reset_regs", regs_flat, 128'd0);
        chk("reset_busy", {127'd0, busy}, 128'd0);
        wait_cyc(2);
        presetn = 1'b1;
        for (int k = 0; k < 16; k++) mregs[k] = 8'h00;
        mptr = 0;
        ib = int_cnt;
        sda_m = 1'b1;
        wait_cyc(Q);
        i2c_stop();
        chk("reset_no_int", 128'(int_cnt - ib), 128'd0);
        ib = int_cnt;
        i2c_start();
        wb(8'hA0, 1'b0);
        wb(8'h01, 1'b0);
        wb(8'h6E, 1'b0);
        i2c_stop();
        mregs[1] = 8'h6E;
        mptr = 2;
        chk("post_reset_write", regs_flat, model_flat());
        chk("post_reset_int", 128'(int_cnt - ib), 128'd1);
        readback();

        chk("int_single_cycle", 128'(int_wide), 128'd0);
        chk("sdao_stable_scl_high", 128'(viol), 128'd0);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
